// File: rtl/clock_period_meter.sv
// Measures the period and high time of clk_meas_i in clk_i cycles. Also flags
// lock on repeated identical periods and a sticky timeout when the input stops.
module clock_period_meter #(
    parameter int CNT_WIDTH  = 16,
    parameter int LOCK_COUNT = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clk_meas_i,
    output logic [CNT_WIDTH-1:0] period_o,
    output logic [CNT_WIDTH-1:0] high_o,
    output logic                 valid_o,
    output logic                 locked_o,
    output logic                 timeout_o
);

    typedef enum logic {
        ST_IDLE,
        ST_MEASURE
    } state_t;

    // Last count value before the counter would overflow (2^CNT_WIDTH-2).
    localparam logic [CNT_WIDTH-1:0] CNT_LAST  = {{(CNT_WIDTH-1){1'b1}}, 1'b0};
    localparam logic [7:0]           MATCH_MAX = 8'(LOCK_COUNT);

    logic                 r_s1;
    logic                 r_s2;
    logic                 r_s3;
    state_t               r_state;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] r_high_pend;
    logic [7:0]           r_match;
    logic                 r_first;

    logic                 w_rise;
    logic                 w_fall;
    logic [CNT_WIDTH-1:0] w_cnt_inc;
    logic [7:0]           w_match_next;

    assign w_rise    = r_s2 & ~r_s3;
    assign w_fall    = ~r_s2 & r_s3;
    assign w_cnt_inc = r_cnt + CNT_WIDTH'(1);

    // The first period after reset or timeout never counts as a match.
    always_comb begin
        // NOTE: default assignment first so no path through the block infers a latch.
        w_match_next = '0;
        if (!r_first && (w_cnt_inc == period_o)) begin
            if (r_match >= MATCH_MAX) begin
                w_match_next = MATCH_MAX;
            end else begin
                w_match_next = r_match + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_s1        <= 1'b0;
            r_s2        <= 1'b0;
            r_s3        <= 1'b0;
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_high_pend <= '0;
            r_match     <= '0;
            r_first     <= 1'b1;
            period_o    <= '0;
            high_o      <= '0;
            valid_o     <= 1'b0;
            locked_o    <= 1'b0;
            timeout_o   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            r_s1    <= clk_meas_i;
            r_s2    <= r_s1;
            r_s3    <= r_s2;
            valid_o <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        r_cnt   <= '0;
                        r_state <= ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    if (w_rise) begin
                        period_o  <= w_cnt_inc;
                        high_o    <= r_high_pend;
                        valid_o   <= 1'b1;
                        timeout_o <= 1'b0;
                        r_cnt     <= '0;
                        r_match   <= w_match_next;
                        locked_o  <= (w_match_next == MATCH_MAX);
                        r_first   <= 1'b0;
                    end else begin
                        if (w_fall) begin
                            r_high_pend <= w_cnt_inc;
                        end
                        // A rise on the last count still wins over the timeout.
                        if (r_cnt == CNT_LAST) begin
                            timeout_o <= 1'b1;
                            locked_o  <= 1'b0;
                            r_match   <= '0;
                            r_first   <= 1'b1;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clock_period_meter.sv
// Drives one measured clock into a 16-bit and a 4-bit meter and checks both
// against an edge-timestamp reference model, plus fixed-value corner sequences.
module tb_clock_period_meter;

    localparam int LOCK_COUNT = 4;

    logic        clk;
    logic        rst;
    logic        meas;
    logic [15:0] p16, h16;
    logic        v16, l16, t16;
    logic [3:0]  p4, h4;
    logic        v4, l4, t4;

    int n_vec = 0;
    int n_err = 0;

    clock_period_meter #(.CNT_WIDTH(16), .LOCK_COUNT(LOCK_COUNT)) u_dut16 (
        .clk_i(clk), .rst_i(rst), .clk_meas_i(meas),
        .period_o(p16), .high_o(h16), .valid_o(v16), .locked_o(l16), .timeout_o(t16)
    );

    clock_period_meter #(.CNT_WIDTH(4), .LOCK_COUNT(LOCK_COUNT)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .clk_meas_i(meas),
        .period_o(p4), .high_o(h4), .valid_o(v4), .locked_o(l4), .timeout_o(t4)
    );

    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    // Reference model: input samples per clock edge, detection two edges later,
    // periods as differences of detected-rise timestamps.
    int samp[$];
    bit m_armed[2];
    int m_trise[2];
    int m_hpend[2];
    int m_per[2];
    int m_high[2];
    bit m_valid[2];
    bit m_lock[2];
    bit m_to[2];
    int seg0[$];
    int seg1[$];

    function automatic int lim(input int i);
        return (i == 0) ? 65535 : 15;
    endfunction

    // Locked when the last LOCK_COUNT+1 periods since reset/timeout are equal.
    function automatic bit trailing_locked(input int q[$]);
        int run;
        if (q.size() == 0) return 1'b0;
        run = 1;
        for (int n = q.size() - 1; n > 0; n--) begin
            if (q[n] != q[n-1]) break;
            run++;
        end
        return run >= LOCK_COUNT + 1;
    endfunction

    task automatic model_step(input logic m);
        int c;
        bit rise, fall;
        c = samp.size();
        if (rst) begin
            samp.push_back(0);
            for (int i = 0; i < 2; i++) begin
                m_armed[i] = 0; m_trise[i] = 0; m_hpend[i] = 0; m_per[i] = 0;
                m_high[i] = 0; m_valid[i] = 0; m_lock[i] = 0; m_to[i] = 0;
            end
            seg0.delete();
            seg1.delete();
            return;
        end
        rise = (c >= 3) && (samp[c-2] == 1) && (samp[c-3] == 0);
        fall = (c >= 3) && (samp[c-2] == 0) && (samp[c-3] == 1);
        for (int i = 0; i < 2; i++) begin
            m_valid[i] = 0;
            if (!m_armed[i]) begin
                if (rise) begin
                    m_armed[i] = 1;
                    m_trise[i] = c;
                end
            end else if (rise) begin
                m_per[i]   = c - m_trise[i];
                m_high[i]  = m_hpend[i];
                m_valid[i] = 1;
                m_to[i]    = 0;
                m_trise[i] = c;
                if (i == 0) begin
                    seg0.push_back(m_per[0]);
                    m_lock[0] = trailing_locked(seg0);
                end else begin
                    seg1.push_back(m_per[1]);
                    m_lock[1] = trailing_locked(seg1);
                end
            end else begin
                if (fall) m_hpend[i] = c - m_trise[i];
                if (c - m_trise[i] == lim(i)) begin
                    m_to[i]    = 1;
                    m_lock[i]  = 0;
                    m_armed[i] = 0;
                    if (i == 0) seg0.delete(); else seg1.delete();
                end
            end
        end
        samp.push_back(int'(m));
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_vec++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
        end
    endtask

    task automatic compare_all();
        check("u16", {p16, h16, v16, l16, t16},
              {16'(m_per[0]), 16'(m_high[0]), m_valid[0], m_lock[0], m_to[0]});
        check("u4", {12'd0, p4, 12'd0, h4, v4, l4, t4},
              {16'(m_per[1]), 16'(m_high[1]), m_valid[1], m_lock[1], m_to[1]});
    endtask

    // One clk_i cycle: drive at the falling edge, model at the rising edge,
    // compare at the next falling edge.
    task automatic tick(input logic m);
        meas = m;
        @(posedge clk);
        model_step(m);
        @(negedge clk);
        compare_all();
    endtask

    task automatic drive_period(input int h, input int l);
        repeat (h) tick(1'b1);
        repeat (l) tick(1'b0);
    endtask

    typedef struct {
        int h;
        int l;
        int reps;
        int per16;
        int high16;
        bit lock16;
        int per4;
        bit lock4;
        bit to4;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int j, seen, nv, nv_async;

        tbl[0] = '{h: 4, l: 4,  reps: 6, per16: 8,  high16: 4, lock16: 1, per4: 8,  lock4: 1, to4: 0};
        tbl[1] = '{h: 5, l: 5,  reps: 6, per16: 10, high16: 5, lock16: 1, per4: 10, lock4: 1, to4: 0};
        tbl[2] = '{h: 1, l: 1,  reps: 8, per16: 2,  high16: 1, lock16: 1, per4: 2,  lock4: 1, to4: 0};
        tbl[3] = '{h: 3, l: 7,  reps: 4, per16: 10, high16: 3, lock16: 0, per4: 10, lock4: 0, to4: 0};
        tbl[4] = '{h: 7, l: 9,  reps: 3, per16: 16, high16: 7, lock16: 0, per4: 12, lock4: 0, to4: 1};
        tbl[5] = '{h: 2, l: 13, reps: 3, per16: 15, high16: 2, lock16: 0, per4: 15, lock4: 0, to4: 0};

        rst  = 1'b1;
        meas = 1'b0;
        repeat (3) tick(1'b0);
        check("rst_u16", {p16, h16, v16, l16, t16}, 64'd0);
        check("rst_u4", {p4, h4, v4, l4, t4}, 64'd0);
        rst = 1'b0;

        // Table patterns: reps full periods then a two-cycle low tail.
        for (int r = 0; r < 6; r++) begin
            repeat (tbl[r].reps) drive_period(tbl[r].h, tbl[r].l);
            tick(1'b0);
            tick(1'b0);
            check($sformatf("tbl%0d_per16", r), 64'(p16), 64'(tbl[r].per16));
            check($sformatf("tbl%0d_high16", r), 64'(h16), 64'(tbl[r].high16));
            check($sformatf("tbl%0d_lock16", r), 64'(l16), 64'(tbl[r].lock16));
            check($sformatf("tbl%0d_per4", r), 64'(p4), 64'(tbl[r].per4));
            check($sformatf("tbl%0d_lock4", r), 64'(l4), 64'(tbl[r].lock4));
            check($sformatf("tbl%0d_to4", r), 64'(t4), 64'(tbl[r].to4));
        end

        // Lock the 4-bit meter on period 6, then stop the input after one more rise.
        repeat (7) drive_period(3, 3);
        tick(1'b1);
        j = samp.size() - 1;
        tick(1'b1);
        tick(1'b1);
        check("hold_locked_before", 64'(l4), 64'd1);
        check("hold_per_before", 64'(p4), 64'd6);
        seen = -1;
        nv   = 0;
        for (int n = 0; n < 40; n++) begin
            tick(1'b0);
            if (v4) nv++;
            if (t4) begin
                seen = samp.size() - 1;
                break;
            end
        end
        check("timeout_latency", 64'(seen - j), 64'd17);
        check("timeout_locked", 64'(l4), 64'd0);
        check("timeout_no_valid", 64'(nv), 64'd0);
        check("timeout_per_held", 64'(p4), 64'd6);

        // Two rises after a timeout yield exactly one measurement.
        nv = 0;
        for (int n = 0; n < 15; n++) begin
            tick((n % 6) < 3 && n < 12);
            if (v4) nv++;
        end
        check("restart_one_valid", 64'(nv), 64'd1);
        check("restart_to_clear", 64'(t4), 64'd0);
        check("restart_per", 64'(p4), 64'd6);
        check("restart_high", 64'(h4), 64'd3);

        // Randomized periods, including long lows around the 4-bit timeout.
        for (int it = 0; it < 60; it++) begin
            int h, l, reps;
            h    = $urandom_range(1, 9);
            l    = $urandom_range(1, 9);
            if ($urandom_range(0, 5) == 0) l = $urandom_range(12, 16);
            reps = $urandom_range(1, 4);
            repeat (reps) drive_period(h, l);
            if (it == 30) begin
                rst = 1'b1;
                tick(1'b0);
                tick(1'b0);
                rst = 1'b0;
            end
        end

        rst = 1'b1;
        repeat (2) tick(1'b0);
        rst = 1'b0;
        tick(1'b0);

        // Asynchronous input: 13.7 clk_i cycles per period, never on a clock edge.
        nv_async = 0;
        fork
            begin
                #3;
                repeat (80) begin
                    meas = ~meas;
                    #685;
                end
            end
            begin
                for (int i = 0; i < 560; i++) begin
                    @(negedge clk);
                    if (v16) begin
                        nv_async++;
                        check_range("async_per16", int'(p16), 13, 14);
                        check_range("async_high16", int'(h16), 6, 8);
                    end
                    if (v4) begin
                        check_range("async_per4", int'(p4), 13, 14);
                        check_range("async_high4", int'(h4), 6, 8);
                    end
                    if (i == 300) begin
                        check("async_pre_rst", 64'(p16 != 16'd0), 64'd1);
                        #20 rst = 1'b1;
                        #10;
                        check("async_rst_u16", {p16, h16, v16, l16, t16}, 64'd0);
                        check("async_rst_u4", {p4, h4, v4, l4, t4}, 64'd0);
                        @(negedge clk);
                        rst = 1'b0;
                    end
                end
            end
        join
        check("async_valid_count", 64'(nv_async >= 30), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
